// File: rtl/chip8_keypad_pkg.sv
// chip8_keypad_pkg: shared keypad constants, key map and scan FSM state type
//   NUM_KEYS  number of hex keys on the matrix
//   KEY_NONE  newest_key_down code meaning "no key event latched"
//   KEY_MAP   (row*4 + col) -> hex key code, row 0 top, col 0 left
package chip8_keypad_pkg;
    localparam int NUM_KEYS = 16;
    localparam logic [4:0] KEY_NONE = 5'd16;
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hF, 4'hB, 4'h0, 4'hA,
        4'hE, 4'h9, 4'h8, 4'h7,
        4'hD, 4'h6, 4'h5, 4'h4,
        4'hC, 4'h3, 4'h2, 4'h1
    };
    typedef enum logic {DRIVE, SAMPLE} scan_state_t;
endpackage

// File: rtl/chip8_key_debounce.sv
// chip8_key_debounce: per-key scan-count debouncer
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   raw        in   latest sampled key state (1 = held)
//   scan_done  in   one-cycle strobe after a full matrix scan
//   debounced  out  registered debounced key state
//   rise/fall  out  combinational strobes, high in the cycle before debounced flips 0->1 / 1->0
module chip8_key_debounce
    import chip8_keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic scan_done,
    output logic debounced,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    logic [CW-1:0] cnt;
    logic flip;
    // Flip on the scan that would bring the disagreement count to DEBOUNCE_SCANS.
    assign flip = scan_done && (raw != debounced) && (cnt == CW'(DEBOUNCE_SCANS - 1));
    assign rise = flip && !debounced;
    assign fall = flip && debounced;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            debounced <= 1'b0;
        end else if (scan_done) begin
            if (raw == debounced) begin
                cnt <= '0;
            end else if (flip) begin
                cnt       <= '0;
                debounced <= ~debounced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/chip8_keypad.sv
// chip8_keypad: 4x4 active-low matrix keypad scanner, debouncer and newest-key latch
//   instruction_clk        in   sole clock
//   rst                    in   synchronous active-high reset
//   key_cols_n[3:0]        in   async active-low columns
//   clear_newest_key_down  in   pulse: discard latched newest key
//   key_rows_n[3:0]        out  one-hot-low row drive
//   input_keys[15:0]       out  debounced key image, bit k = hex key k
//   newest_key_down[4:0]   out  latest key event code, 16 = none
// Build option CHIP8_KEYPAD_RELEASE_EN: latch events on key release instead of press.
module chip8_keypad
    import chip8_keypad_pkg::*;
#(
    parameter int SETTLE_TICKS   = 3,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        instruction_clk,
    input  logic        rst,
    input  logic [3:0]  key_cols_n,
    input  logic        clear_newest_key_down,
    output logic [3:0]  key_rows_n,
    output logic [15:0] input_keys,
    output logic [4:0]  newest_key_down
);
`ifdef CHIP8_KEYPAD_RELEASE_EN
    localparam bit RELEASE_EV = 1'b1;
`else
    localparam bit RELEASE_EV = 1'b0;
`endif
    localparam int SW = $clog2(SETTLE_TICKS + 1);

    scan_state_t         state;
    logic [1:0]          row;
    logic [SW-1:0]       settle;
    logic [3:0]          cols_meta, cols_sync;
    logic [NUM_KEYS-1:0] raw, rise, fall, ev;
    logic                scan_done;
    logic [4:0]          ev_code;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        chip8_key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_db (
            .clk       (instruction_clk),
            .rst       (rst),
            .raw       (raw[k]),
            .scan_done (scan_done),
            .debounced (input_keys[k]),
            .rise      (rise[k]),
            .fall      (fall[k])
        );
    end

    assign ev = RELEASE_EV ? fall : rise;

    // Lowest key code wins when several keys flip on the same scan.
    always_comb begin
        ev_code = KEY_NONE;
        for (int k = NUM_KEYS - 1; k >= 0; k--)
            if (ev[k]) ev_code = 5'(k);
    end

    always_ff @(posedge instruction_clk) begin
        if (rst) begin
            state           <= DRIVE;
            row             <= 2'd0;
            settle          <= '0;
            key_rows_n      <= 4'b1110;
            raw             <= '0;
            scan_done       <= 1'b0;
            cols_meta       <= 4'hF;
            cols_sync       <= 4'hF;
            newest_key_down <= KEY_NONE;
        end else begin
            cols_meta <= key_cols_n;
            cols_sync <= cols_meta;
            scan_done <= 1'b0;
            case (state)
                DRIVE: begin
                    if (settle == SW'(SETTLE_TICKS - 1)) begin
                        settle <= '0;
                        state  <= SAMPLE;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                SAMPLE: begin
                    for (int c = 0; c < 4; c++)
                        raw[KEY_MAP[{row, 2'(c)}]] <= ~cols_sync[c];
                    row        <= row + 2'd1;
                    key_rows_n <= ~(4'b0001 << (row + 2'd1));
                    scan_done  <= (row == 2'd3);
                    state      <= DRIVE;
                end
                default: state <= DRIVE;
            endcase
            // A new event beats a simultaneous clear so no key is ever lost.
            if (ev_code != KEY_NONE)
                newest_key_down <= ev_code;
            else if (clear_newest_key_down)
                newest_key_down <= KEY_NONE;
        end
    end
endmodule

// File: tb/tb_chip8_keypad.sv
// tb_chip8_keypad: directed self-checking bench for chip8_keypad with a behavioural key matrix
module tb_chip8_keypad;
`ifdef CHIP8_KEYPAD_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif
    localparam logic [3:0] BMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hC,
                                         4'h4, 4'h5, 4'h6, 4'hD,
                                         4'h7, 4'h8, 4'h9, 4'hE,
                                         4'hA, 4'h0, 4'hB, 4'hF};
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  cols, rows;
    logic [15:0] keys;
    logic [4:0]  newest;
    logic [15:0] pressed = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Column c is pulled low when a pressed key sits on the driven row at column c.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && pressed[BMAP[r*4+c]]) cols[c] = 1'b0;
    end

    chip8_keypad dut (
        .instruction_clk       (clk),
        .rst                   (rst),
        .key_cols_n            (cols),
        .clear_newest_key_down (clear),
        .key_rows_n            (rows),
        .input_keys            (keys),
        .newest_key_down       (newest)
    );

    task automatic wait_keys(input logic [15:0] want, input int limit);
        for (int i = 0; i < limit && keys !== want; i++) @(negedge clk);
    endtask

    task automatic wait_rows(input logic [3:0] want, input int limit);
        for (int i = 0; i < limit && rows !== want; i++) @(negedge clk);
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] want;
        pressed = 16'h0020;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rows !== 4'b1110) begin errors++; $display("FAIL reset_rows: got %b want 1110", rows); end
        checks++; if (keys !== 16'h0) begin errors++; $display("FAIL reset_keys: got %h want 0000", keys); end
        checks++; if (newest !== 5'd16) begin errors++; $display("FAIL reset_newest: got %0d want 16", newest); end
        rst = 1'b0;
        pressed = '0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            want = 4'b1111 ^ (4'b0001 << ((i / 4) % 4));
            checks++; if (rows !== want) begin errors++; $display("FAIL row_seq[%0d]: got %b want %b", i, rows, want); end
        end
        repeat (64) @(negedge clk);
    endtask

    task automatic test_press;
        bit bad = 0;
        pressed = 16'h0020;
        wait_keys(16'h0020, 64);
        checks++; if (keys !== 16'h0020) begin errors++; $display("FAIL press_keys: got %h want 0020", keys); end
        checks++; if (newest !== (REL ? 5'd16 : 5'd5)) begin errors++; $display("FAIL press_newest: got %0d want %0d", newest, REL ? 16 : 5); end
        for (int i = 0; i < 500 && !bad; i++) begin
            @(negedge clk);
            if (keys !== 16'h0020 || newest !== (REL ? 5'd16 : 5'd5)) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL hold_stable: got keys %h newest %0d want 0020/%0d", keys, newest, REL ? 16 : 5); end
        pressed = '0;
        wait_keys(16'h0, 64);
        checks++; if (keys !== 16'h0) begin errors++; $display("FAIL release_keys: got %h want 0000", keys); end
        checks++; if (newest !== 5'd5) begin errors++; $display("FAIL release_newest: got %0d want 5", newest); end
    endtask

    task automatic test_bounce;
        bit bad = 0;
        pulse_clear();
        checks++; if (newest !== 5'd16) begin errors++; $display("FAIL bounce_clear: got %0d want 16", newest); end
        // A 24-cycle bounce period does not alias with the 16-cycle scan, so at most
        // two consecutive scans see the key down.
        for (int i = 0; i < 300; i++) begin
            if (i % 12 == 0) pressed = pressed ^ 16'h0020;
            @(negedge clk);
            if (!bad && (keys !== 16'h0 || newest !== 5'd16)) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL bounce_ignored: got keys %h newest %0d want 0000/16", keys, newest); end
        pressed = '0;
        repeat (64) @(negedge clk);
        checks++; if (keys !== 16'h0) begin errors++; $display("FAIL bounce_after: got %h want 0000", keys); end
    endtask

    task automatic test_handshake;
        pressed = 16'h0020;
        wait_keys(16'h0020, 64);
        checks++; if (newest !== (REL ? 5'd16 : 5'd5)) begin errors++; $display("FAIL hs_newest: got %0d want %0d", newest, REL ? 16 : 5); end
        pulse_clear();
        checks++; if (newest !== 5'd16) begin errors++; $display("FAIL hs_clear: got %0d want 16", newest); end
        checks++; if (keys !== 16'h0020) begin errors++; $display("FAIL hs_keys_kept: got %h want 0020", keys); end
        pulse_clear();
        checks++; if (newest !== 5'd16) begin errors++; $display("FAIL hs_clear_idle: got %0d want 16", newest); end
        // Align on the first cycle of row 0 (the end-of-scan cycle); key A then debounces
        // on the edge closing the third following scan, 48 cycles on.
        wait_rows(4'b0111, 20);
        wait_rows(4'b1110, 20);
        checks++; if (rows !== 4'b1110) begin errors++; $display("FAIL hs_align: got %b want 1110", rows); end
        pressed = 16'h0420;
        repeat (48) @(negedge clk);
        checks++; if (keys !== 16'h0020) begin errors++; $display("FAIL hs_pre_flip: got %h want 0020", keys); end
        pulse_clear();
        checks++; if (keys !== 16'h0420) begin errors++; $display("FAIL hs_flip_keys: got %h want 0420", keys); end
        checks++; if (newest !== (REL ? 5'd16 : 5'd10)) begin errors++; $display("FAIL hs_event_wins: got %0d want %0d", newest, REL ? 16 : 10); end
        pressed = '0;
        wait_keys(16'h0, 64);
        pulse_clear();
    endtask

    task automatic test_multi;
        pressed = 16'h1008;
        for (int i = 0; i < 64 && keys === 16'h0; i++) @(negedge clk);
        checks++; if (keys !== 16'h1008) begin errors++; $display("FAIL multi_keys: got %h want 1008", keys); end
        checks++; if (newest !== (REL ? 5'd16 : 5'd3)) begin errors++; $display("FAIL multi_newest: got %0d want %0d", newest, REL ? 16 : 3); end
        wait_rows(4'b1011, 20);
        checks++; if (rows !== 4'b1011) begin errors++; $display("FAIL multi_row2: got %b want 1011", rows); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rows !== 4'b1110) begin errors++; $display("FAIL mrst_rows: got %b want 1110", rows); end
        checks++; if (keys !== 16'h0) begin errors++; $display("FAIL mrst_keys: got %h want 0000", keys); end
        checks++; if (newest !== 5'd16) begin errors++; $display("FAIL mrst_newest: got %0d want 16", newest); end
        rst = 1'b0;
        wait_keys(16'h1008, 64);
        checks++; if (keys !== 16'h1008) begin errors++; $display("FAIL mrst_redebounce: got %h want 1008", keys); end
        checks++; if (newest !== (REL ? 5'd16 : 5'd3)) begin errors++; $display("FAIL mrst_newest2: got %0d want %0d", newest, REL ? 16 : 3); end
        pressed = '0;
        wait_keys(16'h0, 64);
        pulse_clear();
    endtask

    task automatic test_release_cfg;
        pressed = 16'h8000;
        wait_keys(16'h8000, 64);
        checks++; if (keys !== 16'h8000) begin errors++; $display("FAIL cfg_keys: got %h want 8000", keys); end
        checks++; if (newest !== (REL ? 5'd16 : 5'd15)) begin errors++; $display("FAIL cfg_held_newest: got %0d want %0d", newest, REL ? 16 : 15); end
        pressed = '0;
        wait_keys(16'h0, 64);
        checks++; if (keys !== 16'h0) begin errors++; $display("FAIL cfg_release_keys: got %h want 0000", keys); end
        checks++; if (newest !== 5'd15) begin errors++; $display("FAIL cfg_released_newest: got %0d want 15", newest); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_handshake();
        test_multi();
        test_release_cfg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
